// File: rtl/sccomp_run_ctrl_if.sv
// Handshake/debug bundle between the sccomp run controller and the core + host side.
interface sccomp_run_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              start;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] reg_data;
  logic              cpu_rstn;
  logic              cpu_run;
  logic [ADDR_W-1:0] reg_sel;
  logic              dump_valid;
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    input  start, pc_in, reg_data,
    output cpu_rstn, cpu_run, reg_sel, dump_valid, dump_idx, dump_data,
           busy, done, timeout, cycle_count
  );

  modport slave (
    output start, pc_in, reg_data,
    input  cpu_rstn, cpu_run, reg_sel, dump_valid, dump_idx, dump_data,
           busy, done, timeout, cycle_count
  );
endinterface

// File: rtl/sccomp_run_ctrl.sv
// Run controller for sccomp: reset/run sequencing, halt/timeout detection and
// a register-file sweep through the core's Reg_Sel/Reg_Data debug port.
module sccomp_run_ctrl #(
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 1024,
  parameter int HALT_CYCLES = 4,
  parameter int REG_FIRST   = 0,
  parameter int REG_LAST    = 31,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  sccomp_run_ctrl_if.master bus
);
  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int SC_W = $clog2(HALT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] SEL_FIRST = ADDR_W'(REG_FIRST);
  localparam logic [ADDR_W-1:0] SEL_LAST  = ADDR_W'(REG_LAST);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_CYCLES);
  localparam logic [RC_W-1:0]   RC_LAST   = RC_W'(RST_CYCLES - 1);
  localparam logic [SC_W-1:0]   SC_HALT   = SC_W'(HALT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_RESET, S_RUN, S_DUMP, S_DONE} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } dump_word_t;

  state_t            state, state_nxt;
  logic [RC_W-1:0]   rst_cnt;
  logic [SC_W-1:0]   stable_cnt;
  logic [SC_W-1:0]   stable_nxt;
  logic [DATA_W-1:0] pc_prev;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [CNT_W-1:0]  cycle_inc;
  logic              timeout_q;
  logic [ADDR_W-1:0] sel_q;
  // vld_pipe[0]: sel_q addresses a word still to be sampled; vld_pipe[1]: word_q holds a strobe
  logic [1:0]        vld_pipe;
  dump_word_t        word_q;

  logic run_first, pc_same, halt_hit, budget_hit, sweep_last;

  // cycle_cnt is zeroed on every start, so zero in RUN marks the first RUN cycle
  assign run_first  = (cycle_cnt == '0);
  assign pc_same    = (bus.pc_in == pc_prev);
  assign stable_nxt = (run_first || !pc_same) ? '0 : stable_cnt + 1'b1;
  assign halt_hit   = (stable_nxt == SC_HALT);
  assign cycle_inc  = (cycle_cnt == CNT_MAX) ? cycle_cnt : cycle_cnt + 1'b1;
  assign budget_hit = (cycle_inc == CNT_MAX);
  assign sweep_last = vld_pipe[1] && (word_q.idx == SEL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.cpu_rstn = 1'b1;
    bus.cpu_run  = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    unique case (state)
      S_IDLE: begin
        bus.cpu_rstn = 1'b0;
        if (bus.start) state_nxt = S_RESET;
      end
      S_RESET: begin
        bus.cpu_rstn = 1'b0;
        bus.busy     = 1'b1;
        if (rst_cnt == RC_LAST) state_nxt = S_RUN;
      end
      S_RUN: begin
        bus.cpu_run = 1'b1;
        bus.busy    = 1'b1;
        if (halt_hit || budget_hit) state_nxt = S_DUMP;
      end
      S_DUMP: begin
        bus.busy = 1'b1;
        if (sweep_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        if (bus.start) state_nxt = S_RESET;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_cnt    <= '0;
      stable_cnt <= '0;
      pc_prev    <= '0;
      cycle_cnt  <= '0;
      timeout_q  <= 1'b0;
      sel_q      <= SEL_FIRST;
      vld_pipe   <= '0;
      word_q     <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      // Reg_Data is combinational from reg_sel, so it is captured one cycle after the select
      if (vld_pipe[0]) begin
        word_q.idx  <= sel_q;
        word_q.data <= bus.reg_data;
      end
      unique case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            rst_cnt   <= '0;
            cycle_cnt <= '0;
            timeout_q <= 1'b0;
          end
        end
        S_RESET: rst_cnt <= rst_cnt + 1'b1;
        S_RUN: begin
          pc_prev    <= bus.pc_in;
          stable_cnt <= stable_nxt;
          cycle_cnt  <= cycle_inc;
          if (halt_hit || budget_hit) begin
            vld_pipe[0] <= 1'b1;
            sel_q       <= SEL_FIRST;
          end
          // halt takes priority when both land on the same cycle
          if (budget_hit && !halt_hit) timeout_q <= 1'b1;
        end
        S_DUMP: begin
          if (vld_pipe[0]) begin
            if (sel_q == SEL_LAST) begin
              vld_pipe[0] <= 1'b0;
              sel_q       <= SEL_FIRST;
            end else begin
              sel_q <= sel_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.reg_sel     = sel_q;
  assign bus.dump_valid  = vld_pipe[1];
  assign bus.dump_idx    = word_q.idx;
  assign bus.dump_data   = word_q.data;
  assign bus.timeout     = timeout_q;
  assign bus.cycle_count = cycle_cnt;

endmodule
